// File: rtl/i2c_slave_regmap_ctrl_if.sv
// Byte-stream and host-port bundle between the I2C slave engine, the local host
// and the register-map controller.
interface i2c_slave_regmap_ctrl_if #(parameter int AW = 4);
    logic          i2c_start;
    logic          i2c_stop;
    logic [7:0]    i2c_rx_data;
    logic          i2c_received;
    logic          i2c_sended;
    logic [7:0]    i2c_tx_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_ack;
    logic          reg_wr;
    logic [AW-1:0] reg_wr_addr;
    logic          xfer_done;
    logic          xfer_wrote;

    modport slave (
        input  i2c_start, i2c_stop, i2c_rx_data, i2c_received, i2c_sended,
               host_req, host_we, host_addr, host_wdata,
        output i2c_tx_data, host_rdata, host_ack, reg_wr, reg_wr_addr,
               xfer_done, xfer_wrote
    );

    modport master (
        output i2c_start, i2c_stop, i2c_rx_data, i2c_received, i2c_sended,
               host_req, host_we, host_addr, host_wdata,
        input  i2c_tx_data, host_rdata, host_ack, reg_wr, reg_wr_addr,
               xfer_done, xfer_wrote
    );
endinterface

// File: rtl/i2c_slave_regmap_ctrl.sv
// Turns the I2C slave byte stream into pointer-addressed accesses of a 2^AW byte
// register bank, shared with a local host port (I2C writes take priority).
module i2c_slave_regmap_ctrl #(
    parameter int              AW      = 4,
    parameter logic [(1<<AW)-1:0] RO_MASK = '0,
    parameter bit              WRAP    = 1'b1,
    parameter logic [7:0]      RST_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    i2c_slave_regmap_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_e;

    state_e        state_q;
    logic [AW-1:0] ptr_q, ptr_inc;
    logic [7:0]    bank_q [DEPTH];
    logic          rx_q, tx_q, wrote_q;
    logic          reg_wr_q, xfer_done_q, xfer_wrote_q, host_ack_q;
    logic [AW-1:0] reg_wr_addr_q;
    logic [7:0]    tx_data_q, host_rdata_q;
    logic          rx_ev, tx_ev, i2c_wr, host_go, host_wr;

    assign rx_ev   = bus.i2c_received & ~rx_q;
    assign tx_ev   = bus.i2c_sended & ~tx_q;
    // START/STOP in the same cycle as a byte event take precedence over it.
    assign i2c_wr  = (state_q == WDATA) && rx_ev && !bus.i2c_start && !bus.i2c_stop
                     && !RO_MASK[ptr_q];
    assign host_go = bus.host_req & ~host_ack_q;
    assign host_wr = host_go & bus.host_we & ~i2c_wr;
    assign ptr_inc = (WRAP || ptr_q != '1) ? ptr_q + AW'(1) : ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            wrote_q       <= 1'b0;
            rx_q          <= 1'b1;
            tx_q          <= 1'b1;
            reg_wr_q      <= 1'b0;
            reg_wr_addr_q <= '0;
            xfer_done_q   <= 1'b0;
            xfer_wrote_q  <= 1'b0;
        end else begin
            rx_q        <= bus.i2c_received;
            tx_q        <= bus.i2c_sended;
            reg_wr_q    <= i2c_wr;
            xfer_done_q <= 1'b0;
            if (i2c_wr) reg_wr_addr_q <= ptr_q;
            if (bus.i2c_start) begin
                state_q <= PTR;
                wrote_q <= 1'b0;
            end else if (bus.i2c_stop) begin
                if (state_q != IDLE) begin
                    xfer_done_q  <= 1'b1;
                    xfer_wrote_q <= wrote_q;
                end
                state_q <= IDLE;
            end else begin
                case (state_q)
                    PTR: begin
                        if (rx_ev) begin
                            ptr_q   <= bus.i2c_rx_data[AW-1:0];
                            state_q <= WDATA;
                        end else if (tx_ev) begin
                            ptr_q   <= ptr_inc;
                            state_q <= RDATA;
                        end
                    end
                    WDATA: begin
                        if (rx_ev) begin
                            ptr_q <= ptr_inc;
                            if (i2c_wr) wrote_q <= 1'b1;
                        end
                    end
                    RDATA: if (tx_ev) ptr_q <= ptr_inc;
                    default: ;
                endcase
            end
        end
    end

    // A deferred host write is retried next cycle because host_req is held until ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= RST_VAL;
            tx_data_q    <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
        end else begin
            if (i2c_wr)       bank_q[ptr_q]         <= bus.i2c_rx_data;
            else if (host_wr) bank_q[bus.host_addr] <= bus.host_wdata;
            tx_data_q  <= bank_q[ptr_q];
            host_ack_q <= host_go & ~(bus.host_we & i2c_wr);
            if (host_go && !bus.host_we) host_rdata_q <= bank_q[bus.host_addr];
        end
    end

    assign bus.i2c_tx_data = tx_data_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_wr_addr = reg_wr_addr_q;
    assign bus.xfer_done   = xfer_done_q;
    assign bus.xfer_wrote  = xfer_wrote_q;
endmodule

// File: tb/tb_i2c_slave_regmap_ctrl.sv
// Bench: a wrapping and a saturating instance share one stimulus stream; a
// register-map model feeds expectation queues that a negedge monitor drains.
module tb_i2c_slave_regmap_ctrl;
    localparam int         AW  = 4;
    localparam logic [15:0] RO  = 16'h0008;
    localparam logic [7:0] RST = 8'hC3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_regmap_ctrl_if #(.AW(AW)) bw ();
    i2c_slave_regmap_ctrl_if #(.AW(AW)) bs ();

    assign bs.i2c_start    = bw.i2c_start;
    assign bs.i2c_stop     = bw.i2c_stop;
    assign bs.i2c_rx_data  = bw.i2c_rx_data;
    assign bs.i2c_received = bw.i2c_received;
    assign bs.i2c_sended   = bw.i2c_sended;
    assign bs.host_req     = bw.host_req;
    assign bs.host_we      = bw.host_we;
    assign bs.host_addr    = bw.host_addr;
    assign bs.host_wdata   = bw.host_wdata;

    i2c_slave_regmap_ctrl #(.AW(AW), .RO_MASK(RO), .WRAP(1'b1), .RST_VAL(RST)) dut_w (
        .clk(clk), .reset(reset), .bus(bw.slave));
    i2c_slave_regmap_ctrl #(.AW(AW), .RO_MASK(RO), .WRAP(1'b0), .RST_VAL(RST)) dut_s (
        .clk(clk), .reset(reset), .bus(bs.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    logic [7:0] mb [2][16];
    int  mptr [2];
    bit  mwrote [2];
    int  phase;          // 0 idle, 1 expecting pointer, 2 writing, 3 reading
    int  qwr0[$], qwr1[$], qx0[$], qx1[$], qh0[$], qh1[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int adv(int d, int p);
        if (d == 0) return (p + 1) % 16;
        return (p == 15) ? 15 : p + 1;
    endfunction

    function automatic void push(int k, int d, int v);
        case (k * 2 + d)
            0: qwr0.push_back(v);
            1: qwr1.push_back(v);
            2: qx0.push_back(v);
            3: qx1.push_back(v);
            4: qh0.push_back(v);
            default: qh1.push_back(v);
        endcase
    endfunction

    function automatic int pop(int k, int d);
        int v = -1;
        case (k * 2 + d)
            0: if (qwr0.size() > 0) v = qwr0.pop_front();
            1: if (qwr1.size() > 0) v = qwr1.pop_front();
            2: if (qx0.size() > 0) v = qx0.pop_front();
            3: if (qx1.size() > 0) v = qx1.pop_front();
            4: if (qh0.size() > 0) v = qh0.pop_front();
            default: if (qh1.size() > 0) v = qh1.pop_front();
        endcase
        return v;
    endfunction

    function automatic void mon(int d, logic rw, logic [3:0] ra, logic xd, logic xw,
                                logic ha, logic [7:0] hr);
        int e;
        if (rw) begin
            e = pop(0, d);
            if (e < 0) chk($sformatf("spurious reg_wr dut%0d", d), rw, 0);
            else       chk($sformatf("reg_wr_addr dut%0d", d), ra, e);
        end
        if (xd) begin
            e = pop(1, d);
            if (e < 0) chk($sformatf("spurious xfer_done dut%0d", d), xd, 0);
            else       chk($sformatf("xfer_wrote dut%0d", d), xw, e);
        end
        if (ha) begin
            e = pop(2, d);
            if (e < 0)        chk($sformatf("spurious host_ack dut%0d", d), ha, 0);
            else if (e < 256) chk($sformatf("host_rdata dut%0d", d), hr, e);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, bw.reg_wr, bw.reg_wr_addr, bw.xfer_done, bw.xfer_wrote, bw.host_ack, bw.host_rdata);
            mon(1, bs.reg_wr, bs.reg_wr_addr, bs.xfer_done, bs.xfer_wrote, bs.host_ack, bs.host_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mb[d][i] = RST;
            mptr[d] = 0;
            mwrote[d] = 1'b0;
        end
        phase = 0;
    endtask

    task automatic start();
        phase = 1;
        mwrote[0] = 1'b0;
        mwrote[1] = 1'b0;
        bw.i2c_start = 1'b1; cyc(); bw.i2c_start = 1'b0;
    endtask

    task automatic stop();
        if (phase != 0) begin
            push(1, 0, int'(mwrote[0]));
            push(1, 1, int'(mwrote[1]));
        end
        phase = 0;
        bw.i2c_stop = 1'b1; cyc(); bw.i2c_stop = 1'b0;
    endtask

    task automatic rx(logic [7:0] b);
        for (int d = 0; d < 2; d++) begin
            if (phase == 1) mptr[d] = int'(b[3:0]);
            else if (phase == 2) begin
                if (!RO[mptr[d]]) begin
                    mb[d][mptr[d]] = b;
                    push(0, d, mptr[d]);
                    mwrote[d] = 1'b1;
                end
                mptr[d] = adv(d, mptr[d]);
            end
        end
        if (phase == 1) phase = 2;
        bw.i2c_rx_data = b; bw.i2c_received = 1'b1; cyc();
        bw.i2c_received = 1'b0; cyc();
    endtask

    task automatic tx();
        chk("tx_data dut0", bw.i2c_tx_data, mb[0][mptr[0]]);
        chk("tx_data dut1", bs.i2c_tx_data, mb[1][mptr[1]]);
        if (phase == 1 || phase == 3) begin
            mptr[0] = adv(0, mptr[0]);
            mptr[1] = adv(1, mptr[1]);
            phase = 3;
        end
        bw.i2c_sended = 1'b1; cyc();
        bw.i2c_sended = 1'b0; cyc();
    endtask

    task automatic host(bit we, logic [3:0] a, logic [7:0] wd, int exp_lat);
        int lat = 0;
        push(2, 0, we ? 256 : int'(mb[0][a]));
        push(2, 1, we ? 256 : int'(mb[1][a]));
        bw.host_req = 1'b1; bw.host_we = we; bw.host_addr = a; bw.host_wdata = wd;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!bw.host_ack && lat < 10);
        chk("host_ack latency", lat, exp_lat);
        cyc();
        bw.host_req = 1'b0;
        if (we) begin
            mb[0][a] = wd;
            mb[1][a] = wd;
        end
    endtask

    task automatic rd_all();
        for (int a = 0; a < 16; a++) host(1'b0, 4'(a), 8'h00, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bw.i2c_start = 0; bw.i2c_stop = 0; bw.i2c_rx_data = 0; bw.i2c_received = 0;
        bw.i2c_sended = 0; bw.host_req = 0; bw.host_we = 0; bw.host_addr = 0; bw.host_wdata = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx_data", bw.i2c_tx_data, 8'h00);
        chk("reset reg_wr", {bw.reg_wr, bw.xfer_done, bw.host_ack}, 3'b000);
        chk("reset host_rdata", bw.host_rdata, 8'h00);
        reset = 1'b0;
        cyc();
        chk("post-reset tx_data", bw.i2c_tx_data, RST);

        // write burst, then restart-read from the same pointer
        start(); rx(8'h02); rx(8'hA5); rx(8'h5A); stop();
        chk("ptr after burst", mptr[0], 4);
        start(); rx(8'h02); start(); tx(); tx();
        chk("tx_data after read", bw.i2c_tx_data, mb[0][mptr[0]]);
        stop();

        // wrap vs saturate at the top of the bank
        start(); rx(8'h0F); rx(8'h11); rx(8'h22); stop();
        host(1'b0, 4'hF, 8'h00, 1);
        host(1'b0, 4'h0, 8'h00, 1);

        // read-only register from I2C, writable from host
        start(); rx(8'h03); rx(8'h77); stop();
        host(1'b1, 4'h3, 8'h77, 1);
        host(1'b0, 4'h3, 8'h00, 1);

        // host write colliding with an I2C write to the same address
        start(); rx(8'h05);
        fork
            rx(8'h44);
            host(1'b1, 4'h5, 8'h33, 2);
        join
        stop();
        host(1'b0, 4'h5, 8'h00, 1);

        // reset mid-write with i2c_received held high across release
        start(); rx(8'h06); rx(8'h11);
        bw.i2c_rx_data = 8'h0C; bw.i2c_received = 1'b1;
        reset = 1'b1; cyc(); cyc();
        model_reset();
        reset = 1'b0; cyc();
        chk("tx_data after mid reset", bw.i2c_tx_data, RST);
        start(); cyc(); cyc();
        bw.i2c_received = 1'b0; cyc();
        rx(8'h07); rx(8'h99); stop();
        host(1'b0, 4'h6, 8'h00, 1);
        host(1'b0, 4'hC, 8'h00, 1);
        host(1'b0, 4'h7, 8'h00, 1);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0: start();
                1: stop();
                2, 3: rx(8'($urandom_range(0, 255)));
                4: tx();
                5: host(1'b0, 4'($urandom_range(0, 15)), 8'h00, 1);
                default: host(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1);
            endcase
        end
        stop();
        rd_all();
        cyc(); cyc();

        chk("pending reg_wr dut0", qwr0.size(), 0);
        chk("pending reg_wr dut1", qwr1.size(), 0);
        chk("pending xfer_done dut0", qx0.size(), 0);
        chk("pending xfer_done dut1", qx1.size(), 0);
        chk("pending host_ack dut0", qh0.size(), 0);
        chk("pending host_ack dut1", qh1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regmap_ctrl.md
Name: i2c_slave_regmap_ctrl

Overview:
Sequences the byte stream of the team's I2C slave engine into a byte-wide register bank of 2^AW entries. The first byte written after the address phase sets the register pointer. Subsequent written bytes go to the bank with pointer auto-increment, and read transfers stream the bank from the pointer. A local host port shares the bank with the I2C side under fixed-priority arbitration. The block sits between the I2C slave and the system register consumers.

Parameters:
AW, 4, register pointer/address width; bank depth 2^AW
RO_MASK, 0, 2^AW-bit mask; bit i=1 makes register i read-only from I2C (host may still write)
WRAP, 1, 1 = pointer wraps 2^AW-1 -> 0; 0 = pointer saturates at 2^AW-1
RST_VAL, 0, reset value loaded into every register

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
i2c_start  in  1  one-cycle pulse: START/RESTART detected and own address acknowledged
i2c_stop  in  1  one-cycle pulse: STOP detected
i2c_rx_data  in  8  received byte from slave (datareceive)
i2c_received  in  1  level from slave; rising edge = i2c_rx_data valid
i2c_sended  in  1  level from slave; rising edge = current tx byte consumed
i2c_tx_data  out  8  byte presented to slave datasend
host_req  in  1  host access request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host register address
host_wdata  in  8  host write data
host_rdata  out  8  host read data, valid with host_ack
host_ack  out  1  one-cycle completion pulse
reg_wr  out  1  one-cycle pulse per accepted I2C register write
reg_wr_addr  out  AW  address of that write, valid with reg_wr
xfer_done  out  1  one-cycle pulse on STOP ending an addressed transaction
xfer_wrote  out  1  valid with xfer_done: at least one register written by I2C in the transaction

Behaviour:
- Reset values: all outputs 0; state IDLE; ptr=0; bank=RST_VAL; edge-detect history registers=1, so no false edge when reset is released while a level is high.
- Edge detect: rx_ev = i2c_received & ~rx_q; tx_ev = i2c_sended & ~tx_q. rx_q and tx_q are registered copies of the inputs.
- FSM states: IDLE, PTR, WDATA, RDATA.
  - Any state, i2c_start: go to PTR; clear the wrote flag. ptr keeps its value (restart-read from the last pointer).
  - PTR, rx_ev: ptr <= i2c_rx_data[AW-1:0]; upper bits ignored; go to WDATA.
  - PTR, tx_ev (read issued directly after address): ptr advances; go to RDATA.
  - WDATA, rx_ev: write the bank at ptr unless RO_MASK[ptr]; on write, reg_wr=1 next cycle with reg_wr_addr=ptr and wrote flag set; ptr advances regardless of RO.
  - RDATA, tx_ev: ptr advances.
  - i2c_stop in PTR/WDATA/RDATA: go to IDLE; xfer_done=1 next cycle with xfer_wrote=wrote flag. i2c_stop in IDLE: no pulse.
  - i2c_start and i2c_stop in the same cycle: start wins; no xfer_done.
- Pointer advance: if WRAP=1, ptr+1 mod 2^AW. If WRAP=0, hold at 2^AW-1; writes at the saturated address overwrite the same register.
- i2c_tx_data: registered bank[ptr], refreshed every cycle. Updated one cycle after any ptr change or any write to bank[ptr]. The slave samples datasend many clk cycles later, so this latency is acceptable.
- Arbitration:
  - An I2C bank write (WDATA rx_ev) has priority. A host write in the same cycle is held; host_ack is delayed by 1 cycle.
  - Host read: host_rdata=bank[host_addr] with host_ack 1 cycle after host_req, never stalled.
  - Host write to the same address as a simultaneous I2C write: the I2C write lands first, the host write lands the next cycle, so the host value is final.
  - host_ack is not reissued while host_req stays high in the ack cycle; a new request needs host_req re-sampled after ack.
- Reset mid-transaction: state IDLE, ptr 0, bank reloaded. No xfer_done is emitted.

Test Plan:
- Write burst: start; rx bytes 0x02,0xA5,0x5A; stop -> bank[2]=0xA5, bank[3]=0x5A; reg_wr pulses with addr 2,3; xfer_done=1 with xfer_wrote=1; ptr=4.
- Restart read: after the above, start; rx 0x02; start; two tx_ev -> i2c_tx_data shows 0xA5, then 0x5A; ptr ends at 4.
- Wrap/saturate: AW=4, WRAP=1, ptr 0x0F, two writes 0x11,0x22 -> bank[15]=0x11, bank[0]=0x22. With WRAP=0 -> bank[15]=0x22.
- RO register: RO_MASK bit3=1; I2C write to 3 of 0x77 -> bank[3] unchanged, no reg_wr, ptr=4; host write 0x77 to 3 -> bank[3]=0x77.
- Collision: host write addr 5 = 0x33 in the same cycle as an I2C write addr 5 = 0x44 -> host_ack one cycle late; final bank[5]=0x33.
- Reset mid-write: reset asserted between two rx_ev -> no xfer_done; bank=RST_VAL. A subsequent held-high i2c_received produces no rx_ev.
